seq_pattern_gen: RTL and testbench

Serial pattern transmitter, the source end of the valid/d_in bit-stream protocol consumed by the Mealy sequence detectors. It loads a parallel pattern word, either the built-in default 110101 or a caller-supplied word, and shifts it out MSB first, one bit per valid strobe. Each run sends a programmable number of words with programmable idle gaps between them. Downstream backpressure is honoured via hold. Used to drive detector benches and link-training preambles.

---
 rtl/seq_pattern_gen.sv | 199 +++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter feeding valid/d_in bit-stream
// consumers. A pattern word (built-in PATTERN or pat_in) is shifted out MSB
// first, repeat_n words per run with gap_n idle cycles between words.
//
// Ports:
//   clk, res            rising-edge clock, synchronous active-high reset
//   start, use_default  run request (IDLE only) and pattern source select
//   pat_in              user pattern, captured on accepted start
//   repeat_n, gap_n     words per run and idle cycles between words
//   hold                backpressure, freezes bit advance in SHIFT
//   err_inj             (SEQ_GEN_ERR_INJ_EN only) invert the next LSB sent
//   valid, d_out        registered serial bit stream
//   busy, done          run in progress / one-cycle end-of-run pulse
//   word_cnt            words fully sent in the current run
//
// Optional feature macro: SEQ_GEN_ERR_INJ_EN.
module seq_pattern_gen #(
    parameter int unsigned             PAT_W   = 6,
    parameter logic [PAT_W-1:0]        PATTERN = 6'b110101,
    parameter int unsigned             RPT_W   = 4,
    parameter int unsigned             GAP_W   = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [RPT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_n,
    input  logic             hold,
`ifdef SEQ_GEN_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic             valid,
    output logic             d_out,
    output logic             busy,
    output logic             done,
    output logic [RPT_W-1:0] word_cnt
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;      // index of the bit currently on d_out
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;    // remaining idle cycles minus one
    logic               err_q, err_d;
    logic               valid_d, d_d, busy_d, done_d;
    logic [RPT_W-1:0]   wc_d;
    logic [RPT_W-1:0]   wc_inc;
    logic [IDX_W-1:0]   idx_m1;
    logic [PAT_W-1:0]   pat_sel;
    logic               lsb_inv;           // LSB being presented with error flag armed

    assign wc_inc  = word_cnt + RPT_W'(1);
    assign idx_m1  = idx_q - IDX_W'(1);
    assign pat_sel = use_default ? PATTERN : pat_in;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        err_d   = err_q;
        wc_d    = word_cnt;
        valid_d = 1'b0;
        d_d     = d_out;
        busy_d  = busy;
        done_d  = 1'b0;
        lsb_inv = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                err_d  = 1'b0;
                if (start) begin
                    wc_d   = '0;
                    sreg_d = pat_sel;
                    rpt_d  = repeat_n;
                    gap_d  = gap_n;
                    if (repeat_n == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = IDX_MSB;
                        valid_d = 1'b1;
                        d_d     = pat_sel[PAT_W-1];
                        busy_d  = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (!hold) begin
                    if (idx_q == '0) begin
                        // Word complete: finish, chain back-to-back, or idle.
                        wc_d = wc_inc;
                        if (wc_inc == rpt_q) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q == '0) begin
                            idx_d   = IDX_MSB;
                            valid_d = 1'b1;
                            d_d     = sreg_q[PAT_W-1];
                        end else begin
                            state_d = GAP;
                            gcnt_d  = gap_q - GAP_W'(1);
                        end
                    end else begin
                        idx_d   = idx_m1;
                        valid_d = 1'b1;
                        d_d     = sreg_q[idx_m1];
                        if (idx_m1 == '0 && err_q) begin
                            lsb_inv = 1'b1;
                            d_d     = ~sreg_q[0];
                            err_d   = 1'b0;
                        end
                    end
                end
            end

            GAP: begin
                if (gcnt_q == '0) begin
                    state_d = SHIFT;
                    idx_d   = IDX_MSB;
                    valid_d = 1'b1;
                    d_d     = sreg_q[PAT_W-1];
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

`ifdef SEQ_GEN_ERR_INJ_EN
        // Arm on any pulse while busy; an LSB consuming the flag this edge wins.
        if (err_inj && busy && !lsb_inv) begin
            err_d = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            idx_q    <= '0;
            rpt_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            err_q    <= 1'b0;
            valid    <= 1'b0;
            d_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            idx_q    <= idx_d;
            rpt_q    <= rpt_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            err_q    <= err_d;
            valid    <= valid_d;
            d_out    <= d_d;
            busy     <= busy_d;
            done     <= done_d;
            word_cnt <= wc_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: reset state, single and repeated runs,
// user pattern with gaps, hold backpressure, reset abort, zero-length run and
// (with SEQ_GEN_ERR_INJ_EN) LSB error injection.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       use_default;
    logic [5:0] pat_in;
    logic [3:0] repeat_n;
    logic [3:0] gap_n;
    logic       hold;
    logic       err_inj;
    logic       valid;
    logic       d_out;
    logic       busy;
    logic       done;
    logic [3:0] word_cnt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [63:0] bits;
    int n, det, bub, done_cyc, first_cyc, wc_first, wc_gap;

    always #5 clk = ~clk;

    seq_pattern_gen dut (
        .clk         (clk),
        .res         (res),
        .start       (start),
        .use_default (use_default),
        .pat_in      (pat_in),
        .repeat_n    (repeat_n),
        .gap_n       (gap_n),
        .hold        (hold),
`ifdef SEQ_GEN_ERR_INJ_EN
        .err_inj     (err_inj),
`endif
        .valid       (valid),
        .d_out       (d_out),
        .busy        (busy),
        .done        (done),
        .word_cnt    (word_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until done (bounded), recording the valid bit stream and events.
    // Caller sets start=1 and the run inputs beforehand.
    task automatic collect(input int hold_at, input int hold_len, input int restart_at,
                           input int err_at);
        logic [5:0] hist;
        hist = '0;
        bits = '0; n = 0; det = 0; bub = 0;
        done_cyc = -1; first_cyc = -1; wc_first = -1; wc_gap = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 1) start = 1'b0;
            if (valid) begin
                if (first_cyc < 0) begin
                    first_cyc = c;
                    wc_first  = int'(word_cnt);
                end
                bits = {bits[62:0], d_out};
                hist = {hist[4:0], d_out};
                n++;
                if (n >= 6 && hist == 6'b110101) det++;
            end else if (busy) begin
                bub++;
                if (wc_gap < 0) wc_gap = int'(word_cnt);
            end
            if (c == hold_at) hold = 1'b1;
            if (c == hold_at + hold_len) hold = 1'b0;
            if (c == restart_at) begin
                start       = 1'b1;
                use_default = 1'b1;
                repeat_n    = 4'd5;
            end else if (c == restart_at + 1) begin
                start = 1'b0;
            end
            err_inj = (c == err_at);
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        hold    = 1'b0;
        start   = 1'b0;
        err_inj = 1'b0;
    endtask

    initial begin
        res = 1'b1; start = 1'b0; use_default = 1'b0; pat_in = '0;
        repeat_n = '0; gap_n = '0; hold = 1'b0; err_inj = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_d_out", 64'(d_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        res = 1'b0;
        step();

        // Single default word.
        start = 1'b1; use_default = 1'b1; repeat_n = 4'd1; gap_n = 4'd0;
        collect(0, 0, 0, 0);
        chk("t1_bits", bits, 64'b110101);
        chk("t1_nbits", 64'(n), 64'd6);
        chk("t1_first_cyc", 64'(first_cyc), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc), 64'd7);
        chk("t1_det", 64'(det), 64'd1);
        chk("t1_busy_at_done", 64'(busy), 64'd0);
        chk("t1_word_cnt", 64'(word_cnt), 64'd1);
        step();
        chk("t1_done_pulse_end", 64'(done), 64'd0);
        chk("t1_word_cnt_hold", 64'(word_cnt), 64'd1);

        // Three default words back-to-back.
        start = 1'b1; use_default = 1'b1; repeat_n = 4'd3; gap_n = 4'd0;
        collect(0, 0, 0, 0);
        chk("t2_bits", bits, 64'b110101110101110101);
        chk("t2_nbits", 64'(n), 64'd18);
        chk("t2_bubbles", 64'(bub), 64'd0);
        chk("t2_det", 64'(det), 64'd3);
        chk("t2_done_cyc", 64'(done_cyc), 64'd19);
        chk("t2_word_cnt", 64'(word_cnt), 64'd3);
        step();

        // User pattern with 3-cycle gap; a start during the gap is ignored.
        start = 1'b1; use_default = 1'b0; pat_in = 6'b101100; repeat_n = 4'd2; gap_n = 4'd3;
        collect(0, 0, 8, 0);
        chk("t3_bits", bits, 64'b101100101100);
        chk("t3_nbits", 64'(n), 64'd12);
        chk("t3_gap_cycles", 64'(bub), 64'd3);
        chk("t3_wc_in_gap", 64'(wc_gap), 64'd1);
        chk("t3_wc_first", 64'(wc_first), 64'd0);
        chk("t3_done_cyc", 64'(done_cyc), 64'd16);
        chk("t3_word_cnt", 64'(word_cnt), 64'd2);
        step();

        // Hold for 4 cycles after bit 3 of the default word.
        start = 1'b1; use_default = 1'b1; repeat_n = 4'd1; gap_n = 4'd0;
        collect(3, 4, 0, 0);
        chk("t4_bits", bits, 64'b110101);
        chk("t4_nbits", 64'(n), 64'd6);
        chk("t4_hold_cycles", 64'(bub), 64'd4);
        chk("t4_done_cyc", 64'(done_cyc), 64'd11);
        step();

        // Reset during word 2 of 3 with start high in the same cycle.
        start = 1'b1; use_default = 1'b1; repeat_n = 4'd3; gap_n = 4'd0;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("t5_pre_word_cnt", 64'(word_cnt), 64'd1);
        chk("t5_pre_valid", 64'(valid), 64'd1);
        res = 1'b1; start = 1'b1;
        step();
        chk("t5_rst_valid", 64'(valid), 64'd0);
        chk("t5_rst_d_out", 64'(d_out), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_word_cnt", 64'(word_cnt), 64'd0);
        res = 1'b0; start = 1'b0;
        step();
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_idle_done", 64'(done), 64'd0);
        start = 1'b1; repeat_n = 4'd1;
        collect(0, 0, 0, 0);
        chk("t5_fresh_bits", bits, 64'b110101);
        chk("t5_fresh_wc_first", 64'(wc_first), 64'd0);
        chk("t5_fresh_word_cnt", 64'(word_cnt), 64'd1);
        step();

        // Zero-length run: no bits, done next cycle, word_cnt cleared.
        start = 1'b1; repeat_n = 4'd0;
        collect(0, 0, 0, 0);
        chk("t6_nbits", 64'(n), 64'd0);
        chk("t6_done_cyc", 64'(done_cyc), 64'd1);
        chk("t6_word_cnt", 64'(word_cnt), 64'd0);
        step();

`ifdef SEQ_GEN_ERR_INJ_EN
        // Error pulse during word 1 inverts word 1's LSB only.
        start = 1'b1; use_default = 1'b1; repeat_n = 4'd2; gap_n = 4'd0;
        collect(0, 0, 0, 2);
        chk("t7_bits", bits, 64'b110100110101);
        chk("t7_det", 64'(det), 64'd1);
        step();
        // Pulse in IDLE is ignored.
        err_inj = 1'b1;
        step();
        err_inj = 1'b0;
        start = 1'b1; repeat_n = 4'd1;
        collect(0, 0, 0, 0);
        chk("t7_idle_ignored", bits, 64'b110101);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
